fft_r2_delay_stage: RTL and testbench

FFT_R2_DELAY_STAGE -- requirements
Module: fft_r2_delay_stage

---
 rtl/fft_r2_delay_stage_if.sv | 39 +++
 rtl/fft_r2_delay_stage.sv | 171 +++++++++++++++++
 tb/tb_fft_r2_delay_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_r2_delay_stage_if.sv
// Beat-level bus of the radix-2 delay stage: input sample beats towards the
// stage and registered butterfly results back from it.
interface fft_r2_delay_stage_if #(
  parameter int IN_W  = 12,
  parameter int LANES = 16,
  parameter int DEPTH = 2,
  parameter int SCALE = 0
);
  localparam int OUT_W = IN_W + 1 - SCALE;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    din_valid;
  logic                    din_sof;
  logic signed [IN_W-1:0]  din_re      [0:LANES-1];
  logic signed [IN_W-1:0]  din_im      [0:LANES-1];

  logic                    dout_valid;
  logic                    dout_sof;
  logic [IDX_W-1:0]        dout_idx;
  logic signed [OUT_W-1:0] dout_add_re [0:LANES-1];
  logic signed [OUT_W-1:0] dout_add_im [0:LANES-1];
  logic signed [OUT_W-1:0] dout_sub_re [0:LANES-1];
  logic signed [OUT_W-1:0] dout_sub_im [0:LANES-1];
  logic                    err_sof;

  // Upstream side: produces sample beats, consumes results.
  modport master (
    output din_valid, din_sof, din_re, din_im,
    input  dout_valid, dout_sof, dout_idx,
    input  dout_add_re, dout_add_im, dout_sub_re, dout_sub_im, err_sof
  );

  // Stage side: consumes sample beats, produces results.
  modport slave (
    input  din_valid, din_sof, din_re, din_im,
    output dout_valid, dout_sof, dout_idx,
    output dout_add_re, dout_add_im, dout_sub_re, dout_sub_im, err_sof
  );
endinterface

// File: rtl/fft_r2_delay_stage.sv
// Radix-2 delay-line butterfly stage. The first half of every frame is parked
// in a DEPTH-deep buffer; each beat of the second half is combined with the
// matching parked beat into a sum and a difference, registered for output.
// A start-of-frame marker arriving mid-frame restarts frame alignment.
module fft_r2_delay_stage #(
  parameter int IN_W  = 12,
  parameter int LANES = 16,
  parameter int DEPTH = 2,
  parameter int SCALE = 0
) (
  input logic                 clk,
  input logic                 rstn,
  fft_r2_delay_stage_if.slave bus
);
  localparam int OUT_W = IN_W + 1 - SCALE;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(2 * DEPTH);
  localparam int SUM_W = IN_W + 2;

  localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(2 * DEPTH - 1);
  localparam logic [IDX_W-1:0]        IDX_ZERO = {IDX_W{1'b0}};
  localparam logic signed [SUM_W-1:0] RND_ONE  = SUM_W'(1'b1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = {3'b000, {(IN_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN  = {3'b111, {(IN_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};

  // Sign-extend an input sample to the working width of the butterfly.
  function automatic logic signed [SUM_W-1:0] ext_fn(input logic signed [IN_W-1:0] x);
    return {{2{x[IN_W-1]}}, x};
  endfunction

  // Map an exact butterfly result to the output width: either keep it whole
  // (bit growth) or halve it with round-half-up and clamp to the input range.
  function automatic logic signed [OUT_W-1:0] scale_fn(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] h;
    h = (x + RND_ONE) >>> 1;
    if (SCALE == 0) begin
      return x[OUT_W-1:0];
    end else if (h > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (h < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end else begin
      return h[OUT_W-1:0];
    end
  endfunction

  logic [CNT_W-1:0]        beat_cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [IDX_W-1:0]        addr_s;
  logic [IDX_W-1:0]        wr_addr_s;
  logic                    sof_err_s;
  logic                    compute_s;
  logic                    wr_en_s;

  logic signed [IN_W-1:0]  buf_re_r [0:DEPTH-1][0:LANES-1];
  logic signed [IN_W-1:0]  buf_im_r [0:DEPTH-1][0:LANES-1];

  logic signed [OUT_W-1:0] add_re_s [0:LANES-1];
  logic signed [OUT_W-1:0] add_im_s [0:LANES-1];
  logic signed [OUT_W-1:0] sub_re_s [0:LANES-1];
  logic signed [OUT_W-1:0] sub_im_s [0:LANES-1];

  logic                    dout_valid_r;
  logic                    dout_sof_r;
  logic [IDX_W-1:0]        dout_idx_r;
  logic                    err_sof_r;
  logic signed [OUT_W-1:0] add_re_r [0:LANES-1];
  logic signed [OUT_W-1:0] add_im_r [0:LANES-1];
  logic signed [OUT_W-1:0] sub_re_r [0:LANES-1];
  logic signed [OUT_W-1:0] sub_im_r [0:LANES-1];

  // Classify the current beat (fill / compute / realignment) and pick the next beat count.
  always_comb begin
    sof_err_s = bus.din_valid && bus.din_sof && (beat_cnt_r != CNT_ZERO);
    // The top count bit separates the fill half from the compute half.
    compute_s = bus.din_valid && !sof_err_s && beat_cnt_r[CNT_W-1];
    wr_en_s   = bus.din_valid && (sof_err_s || !beat_cnt_r[CNT_W-1]);
    if (DEPTH == 1) begin
      addr_s = IDX_ZERO;
    end else begin
      addr_s = beat_cnt_r[IDX_W-1:0];
    end
    // A realigning beat is stored as beat 0 of the new frame.
    if (sof_err_s) begin
      wr_addr_s = IDX_ZERO;
    end else begin
      wr_addr_s = addr_s;
    end
    if (sof_err_s) begin
      cnt_nxt_s = CNT_ONE;
    end else if (bus.din_valid) begin
      if (beat_cnt_r == CNT_LAST) begin
        cnt_nxt_s = CNT_ZERO;
      end else begin
        cnt_nxt_s = beat_cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = beat_cnt_r;
    end
  end

  // Beat position within the frame; advances only on accepted beats.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      beat_cnt_r <= CNT_ZERO;
    end else begin
      beat_cnt_r <= cnt_nxt_s;
    end
  end

  // First-half delay buffer; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int l = 0; l < LANES; l++) begin
        buf_re_r[wr_addr_s][l] <= bus.din_re[l];
        buf_im_r[wr_addr_s][l] <= bus.din_im[l];
      end
    end
  end

  // Butterfly: parked sample a against incoming sample b, per lane and part.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      add_re_s[l] = scale_fn(ext_fn(buf_re_r[addr_s][l]) + ext_fn(bus.din_re[l]));
      add_im_s[l] = scale_fn(ext_fn(buf_im_r[addr_s][l]) + ext_fn(bus.din_im[l]));
      sub_re_s[l] = scale_fn(ext_fn(buf_re_r[addr_s][l]) - ext_fn(bus.din_re[l]));
      sub_im_s[l] = scale_fn(ext_fn(buf_im_r[addr_s][l]) - ext_fn(bus.din_im[l]));
    end
  end

  // Output register: results and index update only on compute beats, otherwise hold.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      dout_valid_r <= 1'b0;
      dout_sof_r   <= 1'b0;
      dout_idx_r   <= IDX_ZERO;
      err_sof_r    <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        add_re_r[l] <= OUT_ZERO;
        add_im_r[l] <= OUT_ZERO;
        sub_re_r[l] <= OUT_ZERO;
        sub_im_r[l] <= OUT_ZERO;
      end
    end else begin
      dout_valid_r <= compute_s;
      dout_sof_r   <= compute_s && (addr_s == IDX_ZERO);
      err_sof_r    <= sof_err_s;
      if (compute_s) begin
        dout_idx_r <= addr_s;
        for (int l = 0; l < LANES; l++) begin
          add_re_r[l] <= add_re_s[l];
          add_im_r[l] <= add_im_s[l];
          sub_re_r[l] <= sub_re_s[l];
          sub_im_r[l] <= sub_im_s[l];
        end
      end
    end
  end

  assign bus.dout_valid  = dout_valid_r;
  assign bus.dout_sof    = dout_sof_r;
  assign bus.dout_idx    = dout_idx_r;
  assign bus.err_sof     = err_sof_r;
  assign bus.dout_add_re = add_re_r;
  assign bus.dout_add_im = add_im_r;
  assign bus.dout_sub_re = sub_re_r;
  assign bus.dout_sub_im = sub_im_r;
endmodule

// File: tb/tb_fft_r2_delay_stage.sv
// Bench for the radix-2 delay stage: three instances (DEPTH=2 growth,
// DEPTH=2 halving, DEPTH=1 growth) driven with identical beats and compared
// against a frame-level reference model.
module tb_fft_r2_delay_stage;
  localparam int IN_W  = 12;
  localparam int LANES = 16;
  localparam int NDUT  = 3;
  localparam int MAXV  = (1 << (IN_W - 1)) - 1;
  localparam int MINV  = -(1 << (IN_W - 1));

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic din_valid = 1'b0;
  logic din_sof = 1'b0;
  logic signed [IN_W-1:0] s_re [0:LANES-1];
  logic signed [IN_W-1:0] s_im [0:LANES-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_r2_delay_stage_if #(.IN_W(IN_W), .LANES(LANES), .DEPTH(2), .SCALE(0)) b0 ();
  fft_r2_delay_stage_if #(.IN_W(IN_W), .LANES(LANES), .DEPTH(2), .SCALE(1)) b1 ();
  fft_r2_delay_stage_if #(.IN_W(IN_W), .LANES(LANES), .DEPTH(1), .SCALE(0)) b2 ();

  assign b0.din_valid = din_valid;
  assign b0.din_sof   = din_sof;
  assign b0.din_re    = s_re;
  assign b0.din_im    = s_im;
  assign b1.din_valid = din_valid;
  assign b1.din_sof   = din_sof;
  assign b1.din_re    = s_re;
  assign b1.din_im    = s_im;
  assign b2.din_valid = din_valid;
  assign b2.din_sof   = din_sof;
  assign b2.din_re    = s_re;
  assign b2.din_im    = s_im;

  fft_r2_delay_stage #(.IN_W(IN_W), .LANES(LANES), .DEPTH(2), .SCALE(0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0));
  fft_r2_delay_stage #(.IN_W(IN_W), .LANES(LANES), .DEPTH(2), .SCALE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
  fft_r2_delay_stage #(.IN_W(IN_W), .LANES(LANES), .DEPTH(1), .SCALE(0)) dut2 (.clk(clk), .rstn(rstn), .bus(b2));

  // Observed outputs, widened to int so all instances can be indexed uniformly.
  int o_valid [NDUT];
  int o_sof   [NDUT];
  int o_err   [NDUT];
  int o_idx   [NDUT];
  int o_are   [NDUT][LANES];
  int o_aim   [NDUT][LANES];
  int o_sre   [NDUT][LANES];
  int o_sim   [NDUT][LANES];

  // Gather DUT outputs into the observation arrays.
  always_comb begin
    o_valid[0] = int'(b0.dout_valid); o_sof[0] = int'(b0.dout_sof);
    o_err[0]   = int'(b0.err_sof);    o_idx[0] = int'(b0.dout_idx);
    o_valid[1] = int'(b1.dout_valid); o_sof[1] = int'(b1.dout_sof);
    o_err[1]   = int'(b1.err_sof);    o_idx[1] = int'(b1.dout_idx);
    o_valid[2] = int'(b2.dout_valid); o_sof[2] = int'(b2.dout_sof);
    o_err[2]   = int'(b2.err_sof);    o_idx[2] = int'(b2.dout_idx);
    for (int l = 0; l < LANES; l++) begin
      o_are[0][l] = int'(b0.dout_add_re[l]); o_aim[0][l] = int'(b0.dout_add_im[l]);
      o_sre[0][l] = int'(b0.dout_sub_re[l]); o_sim[0][l] = int'(b0.dout_sub_im[l]);
      o_are[1][l] = int'(b1.dout_add_re[l]); o_aim[1][l] = int'(b1.dout_add_im[l]);
      o_sre[1][l] = int'(b1.dout_sub_re[l]); o_sim[1][l] = int'(b1.dout_sub_im[l]);
      o_are[2][l] = int'(b2.dout_add_re[l]); o_aim[2][l] = int'(b2.dout_add_im[l]);
      o_sre[2][l] = int'(b2.dout_sub_re[l]); o_sim[2][l] = int'(b2.dout_sub_im[l]);
    end
  end

  // Reference model: the current frame as a list of stored first-half beats.
  int m_dep [NDUT] = '{2, 2, 1};
  int m_scl [NDUT] = '{0, 1, 0};
  int m_len [NDUT];
  int m_bre [NDUT][64][LANES];
  int m_bim [NDUT][64][LANES];
  int e_valid [NDUT];
  int e_sof   [NDUT];
  int e_err   [NDUT];
  int e_idx   [NDUT];
  int e_are   [NDUT][LANES];
  int e_aim   [NDUT][LANES];
  int e_sre   [NDUT][LANES];
  int e_sim   [NDUT][LANES];

  function automatic int scl(input int x, input int s);
    int h;
    if (s == 0) return x;
    h = (x + 1) >>> 1;
    if (h > MAXV) h = MAXV;
    if (h < MINV) h = MINV;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_len[i] = 0; e_valid[i] = 0; e_sof[i] = 0; e_err[i] = 0; e_idx[i] = 0;
      for (int l = 0; l < LANES; l++) begin
        e_are[i][l] = 0; e_aim[i][l] = 0; e_sre[i][l] = 0; e_sim[i][l] = 0;
      end
    end
  endtask

  task automatic model_edge();
    int k;
    if (rstn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NDUT; i++) begin
      e_valid[i] = 0; e_sof[i] = 0; e_err[i] = 0;
      if (din_valid) begin
        if (din_sof && m_len[i] != 0) begin
          e_err[i] = 1;
          m_len[i] = 0;
        end
        if (m_len[i] < m_dep[i]) begin
          for (int l = 0; l < LANES; l++) begin
            m_bre[i][m_len[i]][l] = int'(s_re[l]);
            m_bim[i][m_len[i]][l] = int'(s_im[l]);
          end
          m_len[i] = m_len[i] + 1;
        end else begin
          k = m_len[i] - m_dep[i];
          e_valid[i] = 1; e_sof[i] = (k == 0) ? 1 : 0; e_idx[i] = k;
          for (int l = 0; l < LANES; l++) begin
            e_are[i][l] = scl(m_bre[i][k][l] + int'(s_re[l]), m_scl[i]);
            e_aim[i][l] = scl(m_bim[i][k][l] + int'(s_im[l]), m_scl[i]);
            e_sre[i][l] = scl(m_bre[i][k][l] - int'(s_re[l]), m_scl[i]);
            e_sim[i][l] = scl(m_bim[i][k][l] - int'(s_im[l]), m_scl[i]);
          end
          m_len[i] = (m_len[i] + 1 == 2 * m_dep[i]) ? 0 : m_len[i] + 1;
        end
      end
    end
  endtask

  task automatic set_all(input int re, input int im);
    for (int l = 0; l < LANES; l++) begin
      s_re[l] = IN_W'(re);
      s_im[l] = IN_W'(im);
    end
  endtask

  task automatic set_rand();
    for (int l = 0; l < LANES; l++) begin
      s_re[l] = IN_W'($urandom);
      s_im[l] = IN_W'($urandom);
    end
  endtask

  // One clock: present controls, advance the model at the edge, settle past it.
  task automatic step(input logic v, input logic s);
    din_valid = v;
    din_sof   = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int nz;
    rstn = 1'b1;
    model_reset();
    repeat (6) begin
      set_rand();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < NDUT; i++) begin
        nz = o_valid[i] | o_sof[i] | o_err[i] | o_idx[i];
        for (int l = 0; l < LANES; l++) nz = nz | o_are[i][l] | o_aim[i][l] | o_sre[i][l] | o_sim[i][l];
        n_cmp++;
        if (nz !== 0) begin
          n_bad++;
          $display("FAIL reset_quiet dut%0d: or-of-outputs=%0d expected 0", i, nz);
        end
      end
    end
    rstn = 1'b0;
    set_all(0, 0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_frame_scale0();
    set_all(100, -50); step(1'b1, 1'b1);
    n_cmp++;
    if (o_valid[0] !== 0) begin n_bad++; $display("FAIL fill0_quiet: valid=%0d expected 0", o_valid[0]); end
    set_all(200, 7); step(1'b1, 1'b0);
    n_cmp++;
    if (o_valid[0] !== 0) begin n_bad++; $display("FAIL fill1_quiet: valid=%0d expected 0", o_valid[0]); end
    // DEPTH=1 instance already paired beats 0 and 1.
    n_cmp++;
    if (o_valid[2] !== 1 || o_sof[2] !== 1 || o_idx[2] !== 0 || o_are[2][5] !== 300 ||
        o_aim[2][5] !== -43 || o_sre[2][5] !== -100 || o_sim[2][5] !== -57) begin
      n_bad++;
      $display("FAIL depth1_pair: v=%0d sof=%0d idx=%0d add=(%0d,%0d) sub=(%0d,%0d) expected 1 1 0 (300,-43) (-100,-57)",
               o_valid[2], o_sof[2], o_idx[2], o_are[2][5], o_aim[2][5], o_sre[2][5], o_sim[2][5]);
    end
    set_all(30, 10); step(1'b1, 1'b0);
    n_cmp++;
    if (o_valid[0] !== 1 || o_sof[0] !== 1 || o_idx[0] !== 0) begin
      n_bad++; $display("FAIL frame_ctrl0: v=%0d sof=%0d idx=%0d expected 1 1 0", o_valid[0], o_sof[0], o_idx[0]);
    end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (o_are[0][l] !== 130 || o_aim[0][l] !== -40 || o_sre[0][l] !== 70 || o_sim[0][l] !== -60) begin
        n_bad++;
        $display("FAIL frame_k0 lane%0d: add=(%0d,%0d) sub=(%0d,%0d) expected (130,-40) (70,-60)",
                 l, o_are[0][l], o_aim[0][l], o_sre[0][l], o_sim[0][l]);
      end
    end
    set_all(-5, -8); step(1'b1, 1'b0);
    n_cmp++;
    if (o_valid[0] !== 1 || o_sof[0] !== 0 || o_idx[0] !== 1 || o_are[0][0] !== 195 ||
        o_aim[0][0] !== -1 || o_sre[0][0] !== 205 || o_sim[0][0] !== 15) begin
      n_bad++;
      $display("FAIL frame_k1: v=%0d sof=%0d idx=%0d add=(%0d,%0d) sub=(%0d,%0d) expected 1 0 1 (195,-1) (205,15)",
               o_valid[0], o_sof[0], o_idx[0], o_are[0][0], o_aim[0][0], o_sre[0][0], o_sim[0][0]);
    end
  endtask

  task automatic test_gap();
    set_all(100, -50); step(1'b1, 1'b0);
    set_all(200, 7);   step(1'b1, 1'b0);
    set_all(30, 10);   step(1'b1, 1'b0);
    repeat (3) begin
      set_rand(); step(1'b0, 1'b0);
      n_cmp++;
      if (o_valid[0] !== 0 || o_sof[0] !== 0 || o_idx[0] !== 0 || o_are[0][3] !== 130 ||
          o_aim[0][3] !== -40 || o_sre[0][3] !== 70 || o_sim[0][3] !== -60) begin
        n_bad++;
        $display("FAIL gap_hold: v=%0d sof=%0d idx=%0d add=(%0d,%0d) sub=(%0d,%0d) expected 0 0 0 (130,-40) (70,-60)",
                 o_valid[0], o_sof[0], o_idx[0], o_are[0][3], o_aim[0][3], o_sre[0][3], o_sim[0][3]);
      end
    end
    set_all(-5, -8); step(1'b1, 1'b0);
    n_cmp++;
    if (o_valid[0] !== 1 || o_idx[0] !== 1 || o_are[0][7] !== 195 || o_sre[0][7] !== 205) begin
      n_bad++;
      $display("FAIL gap_resume: v=%0d idx=%0d add_re=%0d sub_re=%0d expected 1 1 195 205",
               o_valid[0], o_idx[0], o_are[0][7], o_sre[0][7]);
    end
  endtask

  task automatic test_saturate();
    set_all(2047, 0);  step(1'b1, 1'b0);
    set_all(-2048, 0); step(1'b1, 1'b0);
    set_all(-2048, 0); step(1'b1, 1'b0);
    n_cmp++;
    if (o_are[1][0] !== 0 || o_sre[1][0] !== 2047 || o_aim[1][0] !== 0 || o_sim[1][0] !== 0) begin
      n_bad++;
      $display("FAIL sat_k0: add_re=%0d sub_re=%0d add_im=%0d sub_im=%0d expected 0 2047 0 0",
               o_are[1][0], o_sre[1][0], o_aim[1][0], o_sim[1][0]);
    end
    n_cmp++;
    if (o_are[0][15] !== -1 || o_sre[0][15] !== 4095) begin
      n_bad++; $display("FAIL grow_k0: add_re=%0d sub_re=%0d expected -1 4095", o_are[0][15], o_sre[0][15]);
    end
    set_all(-2048, 0); step(1'b1, 1'b0);
    n_cmp++;
    if (o_are[1][9] !== -2048 || o_sre[1][9] !== 0) begin
      n_bad++; $display("FAIL sat_k1: add_re=%0d sub_re=%0d expected -2048 0", o_are[1][9], o_sre[1][9]);
    end
    n_cmp++;
    if (o_are[0][9] !== -4096 || o_sre[0][9] !== 0) begin
      n_bad++; $display("FAIL grow_k1: add_re=%0d sub_re=%0d expected -4096 0", o_are[0][9], o_sre[0][9]);
    end
  endtask

  task automatic test_sof_error();
    set_rand(); step(1'b1, 1'b1);
    set_rand(); step(1'b1, 1'b1);
    for (int i = 0; i < NDUT; i++) begin
      n_cmp++;
      if (o_err[i] !== 1 || o_valid[i] !== 0) begin
        n_bad++; $display("FAIL sof_err_pulse dut%0d: err=%0d valid=%0d expected 1 0", i, o_err[i], o_valid[i]);
      end
    end
    set_rand(); step(1'b0, 1'b1);
    n_cmp++;
    if (o_err[0] !== 0 || o_valid[0] !== 0) begin
      n_bad++; $display("FAIL sof_idle_ignored: err=%0d valid=%0d expected 0 0", o_err[0], o_valid[0]);
    end
    set_rand(); step(1'b1, 1'b0);
    n_cmp++;
    if (o_valid[0] !== 0 || o_err[0] !== 0) begin
      n_bad++; $display("FAIL sof_new_fill: valid=%0d err=%0d expected 0 0", o_valid[0], o_err[0]);
    end
    repeat (2) begin
      set_rand(); step(1'b1, 1'b0);
      n_cmp++;
      if (o_valid[0] !== 1 || o_idx[0] !== e_idx[0] || o_sof[0] !== e_sof[0]) begin
        n_bad++; $display("FAIL sof_new_ctrl: v=%0d idx=%0d sof=%0d expected 1 %0d %0d",
                          o_valid[0], o_idx[0], o_sof[0], e_idx[0], e_sof[0]);
      end
      for (int l = 0; l < LANES; l++) begin
        n_cmp++;
        if (o_are[0][l] !== e_are[0][l] || o_aim[0][l] !== e_aim[0][l] ||
            o_sre[0][l] !== e_sre[0][l] || o_sim[0][l] !== e_sim[0][l]) begin
          n_bad++;
          $display("FAIL sof_new_data lane%0d: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", l,
                   o_are[0][l], o_aim[0][l], o_sre[0][l], o_sim[0][l],
                   e_are[0][l], e_aim[0][l], e_sre[0][l], e_sim[0][l]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int outs;
    int errs;
    outs = 0;
    errs = 0;
    set_rand(); step(1'b1, 1'b1);
    set_rand(); step(1'b1, 1'b0);
    set_rand(); step(1'b1, 1'b0);
    rstn = 1'b1;
    repeat (2) begin set_rand(); step(1'b1, 1'b0); end
    rstn = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_rand();
      step((c < 4) ? 1'b1 : 1'b0, 1'b0);
      outs += o_valid[0];
      errs += o_err[0];
      if (o_valid[0] == 1) begin
        n_cmp++;
        if (o_are[0][c] !== e_are[0][c] || o_sim[0][c] !== e_sim[0][c] || o_idx[0] !== e_idx[0]) begin
          n_bad++;
          $display("FAIL rst_mid_data: add_re=%0d sub_im=%0d idx=%0d expected %0d %0d %0d",
                   o_are[0][c], o_sim[0][c], o_idx[0], e_are[0][c], e_sim[0][c], e_idx[0]);
        end
      end
    end
    n_cmp++;
    if (outs !== 2 || errs !== 0) begin
      n_bad++; $display("FAIL rst_mid_count: outputs=%0d errs=%0d expected 2 0", outs, errs);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      set_rand();
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0));
      for (int i = 0; i < NDUT; i++) begin
        n_cmp++;
        if (o_valid[i] !== e_valid[i] || o_sof[i] !== e_sof[i] || o_err[i] !== e_err[i] || o_idx[i] !== e_idx[i]) begin
          n_bad++;
          $display("FAIL rand_ctrl c%0d dut%0d: v/sof/err/idx=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", c, i,
                   o_valid[i], o_sof[i], o_err[i], o_idx[i], e_valid[i], e_sof[i], e_err[i], e_idx[i]);
        end
        for (int l = 0; l < LANES; l++) begin
          n_cmp++;
          if (o_are[i][l] !== e_are[i][l] || o_aim[i][l] !== e_aim[i][l] ||
              o_sre[i][l] !== e_sre[i][l] || o_sim[i][l] !== e_sim[i][l]) begin
            n_bad++;
            $display("FAIL rand_data c%0d dut%0d lane%0d: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", c, i, l,
                     o_are[i][l], o_aim[i][l], o_sre[i][l], o_sim[i][l],
                     e_are[i][l], e_aim[i][l], e_sre[i][l], e_sim[i][l]);
          end
        end
      end
    end
  endtask

  initial begin
    set_all(0, 0);
    model_reset();
    test_reset();
    test_frame_scale0();
    test_gap();
    test_saturate();
    test_sof_error();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
